// File: rtl/icetap_jtag_pkg.sv
// rtl/icetap_jtag_pkg.sv - slot constants, default widths and slot-name helper for the icetap JTAG DR bank
package icetap_jtag_pkg;

    localparam int DEFAULT_SCAN_N_BITS = 3;
    localparam int DEFAULT_LEN_BITS    = 16;

    localparam int JTAG_REG_VOID         = 0;
    localparam int JTAG_REG_CMD          = 1;
    localparam int JTAG_REG_STATUS       = 2;
    localparam int JTAG_REG_STORE_MASK   = 3;
    localparam int JTAG_REG_TRIGGER_MASK = 4;
    localparam int JTAG_REG_DATA         = 5;

    // Debug text only; never used to build hardware.
    function automatic string jtag_reg_name(input int slot);
        case (slot)
            JTAG_REG_VOID:         return "VOID";
            JTAG_REG_CMD:          return "CMD";
            JTAG_REG_STATUS:       return "STATUS";
            JTAG_REG_STORE_MASK:   return "STORE_MASK";
            JTAG_REG_TRIGGER_MASK: return "TRIGGER_MASK";
            JTAG_REG_DATA:         return "DATA";
            default:               return "UNKNOWN";
        endcase
    endfunction

endpackage

// File: rtl/icetap_jtag_dr_bank_if.sv
// rtl/icetap_jtag_dr_bank_if.sv - TAP-side and register-side signal bundle of the DR bank
interface icetap_jtag_dr_bank_if
    import icetap_jtag_pkg::*;
#(
    parameter int NR_REGS     = 6,
    parameter int SCAN_N_BITS = DEFAULT_SCAN_N_BITS
);
    logic                   tdi;
    logic                   icetap_tdo;
    logic                   test_logic_reset;
    logic                   capture_dr;
    logic                   shift_dr;
    logic                   update_dr;
    logic                   scan_n_ir;
    logic                   extest_ir;
    logic [NR_REGS-1:0]     reg_capture;
    logic [NR_REGS-1:0]     reg_shift_ena;
    logic [NR_REGS-1:0]     reg_update;
    logic                   reg_shift_data;
    logic [NR_REGS-1:0]     reg_tdo;
    logic [SCAN_N_BITS-1:0] active_reg;
    logic                   len_error;

    modport slave (
        input  tdi, test_logic_reset, capture_dr, shift_dr, update_dr,
        input  scan_n_ir, extest_ir, reg_tdo,
        output icetap_tdo, reg_capture, reg_shift_ena, reg_update,
        output reg_shift_data, active_reg, len_error
    );

    modport master (
        output tdi, test_logic_reset, capture_dr, shift_dr, update_dr,
        output scan_n_ir, extest_ir, reg_tdo,
        input  icetap_tdo, reg_capture, reg_shift_ena, reg_update,
        input  reg_shift_data, active_reg, len_error
    );

endinterface

// File: rtl/icetap_jtag_shift_cnt.sv
// rtl/icetap_jtag_shift_cnt.sv - saturating DR shift counter and expected-length compare
module icetap_jtag_shift_cnt
    import icetap_jtag_pkg::*;
#(
    parameter int LEN_BITS = DEFAULT_LEN_BITS
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                i_clr,
    input  logic                i_capture,
    input  logic                i_shift,
    input  logic [LEN_BITS-1:0] i_expected,
    output logic                o_length_ok
);

    logic [LEN_BITS-1:0] r_cnt;

    // Saturation keeps an overlong scan from wrapping back onto a valid length.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_cnt <= '0;
        end else if (i_clr || i_capture) begin
            r_cnt <= '0;
        end else if (i_shift && (r_cnt != '1)) begin
            r_cnt <= r_cnt + LEN_BITS'(1);
        end
    end

    assign o_length_ok = (i_expected == '0) || (r_cnt == i_expected);

endmodule

// File: rtl/icetap_jtag_dr_bank.sv
// rtl/icetap_jtag_dr_bank.sv - SCAN_N-selected DR strobe decode with bypass slot; length check under ICETAP_JTAG_LEN_CHECK_EN
module icetap_jtag_dr_bank
    import icetap_jtag_pkg::*;
#(
    parameter int                          NR_REGS     = 6,
    parameter int                          SCAN_N_BITS = DEFAULT_SCAN_N_BITS,
    parameter int                          LEN_BITS    = DEFAULT_LEN_BITS,
    parameter logic [NR_REGS*LEN_BITS-1:0] REG_LENGTHS = '0
) (
    input logic                  tck,
    input logic                  trst_n,
    icetap_jtag_dr_bank_if.slave bus
);

    logic [SCAN_N_BITS-1:0] r_active_reg;
    logic [SCAN_N_BITS-1:0] r_scan_sr;
    logic                   r_bypass;

    logic               w_tlr;
    logic               w_upd;
    logic               w_shift;
    logic               w_cap;
    logic               w_scan_sel;
    logic               w_data_sel;
    logic               w_void;
    logic               w_slot_sel;
    logic               w_length_ok;
    logic               w_slot_tdo;
    logic               w_scan_valid;
    logic [NR_REGS-1:0] w_onehot;

    // Resolve overlapping TAP decodes so only one action happens per cycle.
    assign w_tlr   = bus.test_logic_reset;
    assign w_upd   = bus.update_dr & ~w_tlr;
    assign w_shift = bus.shift_dr & ~bus.update_dr & ~w_tlr;
    assign w_cap   = bus.capture_dr & ~bus.shift_dr & ~bus.update_dr & ~w_tlr;

    assign w_scan_sel = bus.scan_n_ir;
    assign w_data_sel = bus.extest_ir & ~bus.scan_n_ir;
    assign w_void     = (r_active_reg == SCAN_N_BITS'(JTAG_REG_VOID));
    assign w_slot_sel = w_data_sel & ~w_void;

    assign w_scan_valid = (32'(r_scan_sr) < NR_REGS);

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < NR_REGS; k++) begin
            w_onehot[k] = (r_active_reg == SCAN_N_BITS'(k));
        end
    end

    // Slot 0 never reaches here with w_slot_sel high, so its reg_tdo bit is inert.
    assign w_slot_tdo = |(w_onehot & bus.reg_tdo);

    assign bus.reg_capture   = w_onehot & {NR_REGS{w_slot_sel & w_cap & trst_n}};
    assign bus.reg_shift_ena = w_onehot & {NR_REGS{w_slot_sel & w_shift & trst_n}};
    assign bus.reg_update    = w_onehot & {NR_REGS{w_slot_sel & w_upd & w_length_ok & trst_n}};
    assign bus.reg_shift_data = bus.tdi & (|bus.reg_shift_ena);

    always_comb begin
        bus.icetap_tdo = 1'b0;
        if (trst_n) begin
            if (w_scan_sel) begin
                bus.icetap_tdo = r_scan_sr[0];
            end else if (w_data_sel) begin
                bus.icetap_tdo = w_void ? r_bypass : w_slot_tdo;
            end
        end
    end

    assign bus.active_reg = r_active_reg;

    // Selection is shadowed in r_scan_sr and only committed on Update-DR.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_active_reg <= '0;
            r_scan_sr    <= '0;
            r_bypass     <= 1'b0;
        end else if (w_tlr) begin
            r_active_reg <= '0;
            r_scan_sr    <= '0;
            r_bypass     <= 1'b0;
        end else if (w_scan_sel) begin
            if (w_upd) begin
                r_active_reg <= w_scan_valid ? r_scan_sr : SCAN_N_BITS'(JTAG_REG_VOID);
            end else if (w_shift) begin
                r_scan_sr <= (r_scan_sr >> 1) | (SCAN_N_BITS'(bus.tdi) << (SCAN_N_BITS - 1));
            end else if (w_cap) begin
                r_scan_sr <= r_active_reg;
            end
        end else if (w_data_sel && w_void) begin
            if (w_shift) begin
                r_bypass <= bus.tdi;
            end else if (w_cap) begin
                r_bypass <= 1'b0;
            end
        end
    end

`ifdef ICETAP_JTAG_LEN_CHECK_EN
    logic                r_len_error;
    logic [LEN_BITS-1:0] w_expected;

    always_comb begin
        w_expected = '0;
        for (int k = 0; k < NR_REGS; k++) begin
            if (w_onehot[k]) begin
                w_expected = REG_LENGTHS[k*LEN_BITS +: LEN_BITS];
            end
        end
    end

    icetap_jtag_shift_cnt #(
        .LEN_BITS (LEN_BITS)
    ) u_shift_cnt (
        .tck         (tck),
        .trst_n      (trst_n),
        .i_clr       (w_tlr),
        .i_capture   (w_cap),
        .i_shift     (w_shift),
        .i_expected  (w_expected),
        .o_length_ok (w_length_ok)
    );

    // Sticky until the debugger re-selects a register through SCAN_N.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_len_error <= 1'b0;
        end else if (w_tlr) begin
            r_len_error <= 1'b0;
        end else if (w_scan_sel && w_upd) begin
            r_len_error <= 1'b0;
        end else if (w_slot_sel && w_upd && !w_length_ok) begin
            r_len_error <= 1'b1;
        end
    end

    assign bus.len_error = r_len_error;
`else
    assign w_length_ok   = 1'b1;
    assign bus.len_error = 1'b0;
`endif

endmodule

// File: doc/icetap_jtag_dr_bank.md
# icetap_jtag_dr_bank

Parametrised JTAG data-register bank for icetap: decodes the SCAN_N-selected register into per-register capture/shift/update strobes for `NR_REGS` registers. It sits between the real or virtual TAP and the icetap main block. It adds three behaviours:
- a shadowed SCAN_N selection that commits only on Update-DR;
- a built-in 1-bit bypass register for the VOID slot;
- optional scan-length checking, which suppresses updates after truncated or overlong scans.

## Interface
Parameters:
- `NR_REGS`, 6: number of register slots including VOID (slot 0); 2..2^`SCAN_N_BITS`
- `SCAN_N_BITS`, 3: SCAN_N register width
- `LEN_BITS`, 16: shift-counter and expected-length width
- `REG_LENGTHS`, all 0: `NR_REGS*LEN_BITS` packed; slot k expected length at [k*LEN_BITS +: LEN_BITS]; 0 = any length

Ports:
- `tck`  in  1  JTAG clock; the only clock; all state on posedge
- `trst_n`  in  1  asynchronous, active-low reset
- `tdi`  in  1  JTAG data in
- `icetap_tdo`  out  1  data out to TAP mux
- `test_logic_reset`, `capture_dr`, `shift_dr`, `update_dr`  in  1 each  TAP state decodes
- `scan_n_ir`, `extest_ir`  in  1 each  active instruction
- `reg_capture`  out  `NR_REGS`  capture strobe per slot
- `reg_shift_ena`  out  `NR_REGS`  shift enable per slot
- `reg_update`  out  `NR_REGS`  update strobe per slot
- `reg_shift_data`  out  1  `tdi` while any `reg_shift_ena` bit is high, else 0
- `reg_tdo`  in  `NR_REGS`  serial out of each slot; bit 0 ignored
- `active_reg`  out  `SCAN_N_BITS`  committed SCAN_N value
- `len_error`  out  1  sticky scan-length mismatch flag

## Operation
SCAN_N chain (`scan_n_ir`=1):
- `capture_dr`: `scan_sr` <= `active_reg`
- `shift_dr`: `scan_sr` <= {`tdi`, `scan_sr`[MSB:1]}; `icetap_tdo` = `scan_sr`[0]
- `update_dr`: `active_reg` <= `scan_sr` if `scan_sr` < `NR_REGS`, else 0 (VOID); `len_error` cleared
- The selection never changes mid-shift.

Data scan (`extest_ir`=1, `active_reg`=k):
- k≠0: `reg_capture`[k]=`capture_dr`, `reg_shift_ena`[k]=`shift_dr`, `reg_update`[k]=`update_dr` AND length_ok; all other bits 0; `icetap_tdo` = `reg_tdo`[k].
- k=0: `bypass` flop; `capture_dr` -> 0, `shift_dr` -> `tdi`; `icetap_tdo` = `bypass`; no strobes.
- Any other instruction: all strobes 0, `icetap_tdo` = 0.

Length check:
- `shift_cnt` is cleared on `capture_dr` and incremented on each `shift_dr`, saturating at 2^`LEN_BITS`-1.
- length_ok = (expected[k]==0) OR (`shift_cnt`==expected[k]).
- On `update_dr` with !length_ok: `reg_update`[k] suppressed and `len_error` <= 1.

Reset (`trst_n`=0 async, or `test_logic_reset` sync) clears to 0: `active_reg`, `scan_sr`, `bypass`, `shift_cnt`, `len_error`. While `trst_n`=0 all strobe outputs and `icetap_tdo` are forced 0.

Boundaries:
- TAP inputs are assumed one-hot. If several are asserted, priority is `test_logic_reset` > `update_dr` > `shift_dr` > `capture_dr`.
- `scan_n_ir` and `extest_ir` both high: `scan_n_ir` wins and no slot strobes fire.
- Reset mid-scan abandons the scan and issues no update.

## Timing
- Strobes and `reg_shift_data` are combinational from TAP/IR inputs and registered `active_reg`: zero latency.
- `icetap_tdo` is combinational from flops and `reg_tdo`. The TAP wrapper re-times it on negedge.
- A new `active_reg` is visible on the cycle after `update_dr`; strobes for the new slot appear from the next Capture-DR.
- `len_error` rises the cycle after the offending `update_dr`.
- length_ok uses `shift_cnt` as accumulated before the `update_dr` cycle.

## Configuration
- `ICETAP_JTAG_LEN_CHECK_EN` defined: shift counter, compare and `len_error` are present, as described above.
- Not defined: counter and compare are omitted; `reg_update`[k] follows `update_dr` unconditionally; `len_error` is tied 0; `REG_LENGTHS` is ignored.

## Structure
- Package `icetap_jtag_pkg`: `JTAG_REG_VOID`(0), `JTAG_REG_CMD`, `JTAG_REG_STATUS`, `JTAG_REG_STORE_MASK`, `JTAG_REG_TRIGGER_MASK`, `JTAG_REG_DATA` slot constants; default `SCAN_N_BITS`/`LEN_BITS`; debug text function for slot names.
- Sub-module `icetap_jtag_shift_cnt`: saturating counter plus compare, producing `length_ok`. It is only instantiated under the macro.

## Test plan
- Shift SCAN_N=3'b010 LSB-first then Update-DR -> `active_reg`=2 next cycle. `icetap_tdo` during the shift returns the old value 0,0,0. `active_reg` stays 0 during the shift.
- SCAN_N=7 with `NR_REGS`=6 -> `active_reg`=0. An EXTEST 4-bit scan of 1011 returns 0,1,1,0 through bypass with zero strobes.
- `active_reg`=1, EXTEST: `reg_capture`[1] pulses for 1 cycle, then 8 shifts with `reg_shift_ena`=6'b000010 and `reg_shift_data`=`tdi`. `icetap_tdo` follows `reg_tdo`[1].
- Macro on, expected[1]=8, only 7 shifts then Update-DR -> `reg_update`=0 and `len_error`=1. A following 8-shift scan -> `reg_update`[1] pulses; `len_error` stays 1 until the next SCAN_N update.
- `trst_n` low mid-shift with `active_reg`=5 -> all outputs 0 immediately and `active_reg`=0 after release. The same result via `test_logic_reset` takes effect on the next edge.
- `scan_n_ir`=`extest_ir`=1 with `shift_dr` -> all `reg_shift_ena`=0 and `icetap_tdo`=`scan_sr`[0].
